// File: rtl/mem_stage_router.sv
// Memory-stage front end: decodes load/store addresses onto one-hot target channels,
// stalls until the selected target responds or times out, and registers the MEM/WB result.
module mem_stage_router #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NUM_TGT = 4,
    parameter logic [NUM_TGT*XLEN-1:0] TGT_BASE = {32'h0000_0600, 32'h0000_0400, 32'h0000_0200, 32'h0000_0000},
    parameter logic [NUM_TGT*XLEN-1:0] TGT_MASK = {4{32'hFFFF_FE00}},
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned RD_W = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid_i,
    input  logic                    req_we_i,
    input  logic [XLEN-1:0]         req_addr_i,
    input  logic [XLEN-1:0]         req_wdata_i,
    input  logic [XLEN/8-1:0]       req_be_i,
    input  logic [RD_W-1:0]         req_rd_i,
    output logic [NUM_TGT-1:0]      tgt_sel_o,
    output logic                    tgt_we_o,
    output logic [XLEN-1:0]         tgt_addr_o,
    output logic [XLEN-1:0]         tgt_wdata_o,
    output logic [XLEN/8-1:0]       tgt_be_o,
    input  logic [NUM_TGT-1:0]      tgt_rvalid_i,
    input  logic [NUM_TGT*XLEN-1:0] tgt_rdata_i,
    output logic                    stall_o,
    output logic                    wb_valid_o,
    output logic [RD_W-1:0]         wb_rd_o,
    output logic [XLEN-1:0]         wb_data_o,
    output logic                    err_o,
    output logic [XLEN-1:0]         err_addr_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state, next;
    logic [CW-1:0]       cnt;
    logic [NUM_TGT-1:0]  lat_sel;
    logic                lat_we;
    logic [XLEN-1:0]     lat_addr;
    logic [XLEN-1:0]     lat_wdata;
    logic [XLEN/8-1:0]   lat_be;
    logic [RD_W-1:0]     lat_rd;

    logic [NUM_TGT-1:0]  hits;
    logic [NUM_TGT-1:0]  first_hit;
    logic                any_hit;
    logic [NUM_TGT-1:0]  cur_sel;
    logic                resp;
    logic                timeout;
    logic [XLEN-1:0]     rdata_mux;
    logic                done_ok;
    logic                done_err;
    logic                go_wait;

    // Isolating the lowest set bit gives lowest-index priority without an index encoder.
    always_comb begin
        hits = '0;
        for (int unsigned k = 0; k < NUM_TGT; k++) begin
            hits[k] = ((req_addr_i & TGT_MASK[k*XLEN +: XLEN]) == TGT_BASE[k*XLEN +: XLEN]);
        end
        first_hit = hits & (~hits + NUM_TGT'(1));
        any_hit   = |hits;
    end

    always_comb begin
        cur_sel = '0;
        if (state == S_WAIT) begin
            cur_sel = lat_sel;
        end else if (req_valid_i) begin
            cur_sel = first_hit;
        end
        resp    = |(tgt_rvalid_i & cur_sel);
        timeout = (state == S_WAIT) && (cnt == CW'(TIMEOUT - 1));
        rdata_mux = '0;
        for (int unsigned k = 0; k < NUM_TGT; k++) begin
            if (cur_sel[k]) begin
                rdata_mux = rdata_mux | tgt_rdata_i[k*XLEN +: XLEN];
            end
        end
        go_wait  = (state == S_IDLE) && req_valid_i && any_hit && !resp;
        done_ok  = resp;
        done_err = ((state == S_IDLE) && req_valid_i && !any_hit) ||
                   ((state == S_WAIT) && !resp && timeout);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE: if (go_wait) next = S_WAIT;
            S_WAIT: if (resp || timeout) next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_comb begin
        tgt_sel_o   = '0;
        tgt_we_o    = 1'b0;
        tgt_addr_o  = '0;
        tgt_wdata_o = '0;
        tgt_be_o    = '0;
        stall_o     = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid_i && any_hit) begin
                    tgt_sel_o   = first_hit;
                    tgt_we_o    = req_we_i;
                    tgt_addr_o  = req_addr_i;
                    tgt_wdata_o = req_wdata_i;
                    tgt_be_o    = req_be_i;
                    stall_o     = !resp;
                end
            end
            S_WAIT: begin
                tgt_sel_o   = lat_sel;
                tgt_we_o    = lat_we;
                tgt_addr_o  = lat_addr;
                tgt_wdata_o = lat_wdata;
                tgt_be_o    = lat_be;
                stall_o     = !resp && !timeout;
            end
            default: ;
        endcase
    end

    // The accepting IDLE cycle counts as the first wait cycle, so total stall is TIMEOUT-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            lat_sel    <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            lat_rd     <= '0;
            wb_valid_o <= 1'b0;
            wb_rd_o    <= '0;
            wb_data_o  <= '0;
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else begin
            wb_valid_o <= done_ok || done_err;
            err_o      <= done_err;
            if (go_wait) begin
                cnt       <= CW'(1);
                lat_sel   <= first_hit;
                lat_we    <= req_we_i;
                lat_addr  <= req_addr_i;
                lat_wdata <= req_wdata_i;
                lat_be    <= req_be_i;
                lat_rd    <= req_rd_i;
            end else if (state == S_WAIT) begin
                cnt <= (resp || timeout) ? '0 : cnt + CW'(1);
            end
            if (done_ok) begin
                if ((state == S_WAIT) ? lat_we : req_we_i) begin
                    wb_rd_o   <= '0;
                    wb_data_o <= '0;
                end else begin
                    wb_rd_o   <= (state == S_WAIT) ? lat_rd : req_rd_i;
                    wb_data_o <= rdata_mux;
                end
            end else if (done_err) begin
                wb_rd_o    <= '0;
                wb_data_o  <= '0;
                err_addr_o <= (state == S_WAIT) ? lat_addr : req_addr_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_router.sv
// Bench for mem_stage_router: directed scenarios plus randomized ops checked against a
// transaction-level model of decode, latency and timeout outcome.
module tb_mem_stage_router;

    localparam int XLEN = 32;
    localparam int NT   = 4;
    localparam int TO   = 16;
    localparam int RDW  = 5;
    // Window 3 overlaps windows 0..2, so lowest-index priority decides them.
    localparam logic [NT*XLEN-1:0] BASE = {32'h0000_0000, 32'h0000_0400, 32'h0000_0200, 32'h0000_0000};
    localparam logic [NT*XLEN-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_FE00, 32'hFFFF_FE00, 32'hFFFF_FE00};

    logic            clk, reset;
    logic            req_valid, req_we;
    logic [31:0]     req_addr, req_wdata;
    logic [3:0]      req_be;
    logic [RDW-1:0]  req_rd;
    logic [NT-1:0]   tgt_sel;
    logic            tgt_we;
    logic [31:0]     tgt_addr, tgt_wdata;
    logic [3:0]      tgt_be;
    logic [NT-1:0]   tgt_rvalid;
    logic [NT*32-1:0] tgt_rdata;
    logic            stall, wb_valid, err;
    logic [RDW-1:0]  wb_rd;
    logic [31:0]     wb_data, err_addr;

    mem_stage_router #(
        .XLEN(XLEN), .NUM_TGT(NT), .TGT_BASE(BASE), .TGT_MASK(MASK), .TIMEOUT(TO), .RD_W(RDW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_be_i(req_be), .req_rd_i(req_rd),
        .tgt_sel_o(tgt_sel), .tgt_we_o(tgt_we), .tgt_addr_o(tgt_addr),
        .tgt_wdata_o(tgt_wdata), .tgt_be_o(tgt_be),
        .tgt_rvalid_i(tgt_rvalid), .tgt_rdata_i(tgt_rdata),
        .stall_o(stall), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .err_o(err), .err_addr_o(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_base [NT] = '{32'h0000_0000, 32'h0000_0200, 32'h0000_0400, 32'h0000_0000};
    logic [31:0] m_mask [NT] = '{32'hFFFF_FE00, 32'hFFFF_FE00, 32'hFFFF_FE00, 32'hFFFF_F000};

    int ntotal = 0;
    int npass  = 0;
    logic [RDW-1:0] exp_rd;
    logic [31:0]    exp_data, exp_err_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < NT; k++) begin
            if ((a & m_mask[k]) == m_base[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_held();
        chk("held_rd", 64'(wb_rd), 64'(exp_rd));
        chk("held_data", 64'(wb_data), 64'(exp_data));
        chk("held_err_addr", 64'(err_addr), 64'(exp_err_addr));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_we     = 1'($urandom);
        tgt_rvalid = 4'($urandom);
        #2;
        chk("idle_sel", 64'(tgt_sel), 64'(0));
        chk("idle_stall", 64'(stall), 64'(0));
        @(posedge clk); #1;
        chk("idle_wb_valid", 64'(wb_valid), 64'(0));
        chk("idle_err", 64'(err), 64'(0));
        check_held();
    endtask

    // lat = cycles after acceptance until the selected target responds (0 = same cycle).
    task automatic do_op(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [RDW-1:0] rd, input int lat,
                         input logic [31:0] rdata, input bit noise);
        int k;
        logic [NT-1:0] oh, rv;
        bit done, timed;
        k = decode(addr);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_rd = rd;
        for (int t = 0; t < NT; t++) tgt_rdata[t*32 +: 32] = $urandom;
        if (k < 0) begin
            tgt_rvalid = noise ? 4'hF : 4'($urandom);
            #2;
            chk("miss_sel", 64'(tgt_sel), 64'(0));
            chk("miss_stall", 64'(stall), 64'(0));
            @(posedge clk); #1;
            exp_rd = '0; exp_data = '0; exp_err_addr = addr;
            chk("miss_wb_valid", 64'(wb_valid), 64'(1));
            chk("miss_err", 64'(err), 64'(1));
            check_held();
            return;
        end
        oh = 4'(1 << k);
        done = 1'b0;
        for (int c = 0; c < TO && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
                req_wdata = $urandom; req_be = 4'($urandom); req_rd = RDW'($urandom);
                for (int t = 0; t < NT; t++) tgt_rdata[t*32 +: 32] = $urandom;
            end
            tgt_rdata[k*32 +: 32] = rdata;
            rv = noise ? ~oh : (4'($urandom) & ~oh);
            if (c == lat) rv = rv | oh;
            tgt_rvalid = rv;
            #2;
            chk("sel", 64'(tgt_sel), 64'(oh));
            chk("tgt_addr", 64'(tgt_addr), 64'(addr));
            chk("tgt_we", 64'(tgt_we), 64'(we));
            chk("tgt_wdata", 64'(tgt_wdata), 64'(wdata));
            chk("tgt_be", 64'(tgt_be), 64'(be));
            chk("stall", 64'(stall), 64'((c < lat) && (c != TO - 1)));
            if (c > 0) begin
                chk("wait_wb_valid", 64'(wb_valid), 64'(0));
                chk("wait_err", 64'(err), 64'(0));
            end
            @(posedge clk); #1;
            if (c == lat || c == TO - 1) begin
                done  = 1'b1;
                timed = (c != lat);
                if (timed) begin
                    exp_rd = '0; exp_data = '0; exp_err_addr = addr;
                end else begin
                    exp_rd   = we ? '0 : rd;
                    exp_data = we ? '0 : rdata;
                end
                chk("done_wb_valid", 64'(wb_valid), 64'(1));
                chk("done_err", 64'(err), 64'(timed));
                check_held();
            end
        end
    endtask

    initial begin
        int r, lat;
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; req_rd = '0; tgt_rvalid = '0; tgt_rdata = '0;
        exp_rd = '0; exp_data = '0; exp_err_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", 64'(tgt_sel), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_tgt_we", 64'(tgt_we), 64'(0));
        chk("rst_tgt_addr", 64'(tgt_addr), 64'(0));
        chk("rst_tgt_be", 64'(tgt_be), 64'(0));
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        check_held();
        @(negedge clk); reset = 1'b0;

        // Zero-wait load, 3-cycle peripheral, decode miss, timeout, store ack
        do_op(32'h0000_0040, 1'b0, 32'h0, 4'hF, 5'd7, 0, 32'h1234_5678, 1'b0);
        do_op(32'h0000_0200, 1'b0, 32'h0, 4'hF, 5'd3, 3, 32'hCAFE_0001, 1'b0);
        do_op(32'hFFFF_0000, 1'b0, 32'h0, 4'hF, 5'd9, 0, 32'h0, 1'b0);
        do_op(32'h0000_0400, 1'b0, 32'h0, 4'hF, 5'd4, 100, 32'h0, 1'b0);
        do_op(32'h0000_0010, 1'b1, 32'hAABB_CCDD, 4'b0011, 5'd6, 2, 32'h5555_5555, 1'b0);
        // Foreign rvalid on every other target while waiting on tgt1
        do_op(32'h0000_0204, 1'b0, 32'h0, 4'hF, 5'd12, 4, 32'h0BAD_F00D, 1'b1);
        // Response arriving in the timeout cycle wins
        do_op(32'h0000_0800, 1'b0, 32'h0, 4'hF, 5'd21, TO - 1, 32'h7777_0000, 1'b0);
        idle_cycle();

        // Reset while waiting, then a late rvalid
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0200; req_rd = 5'd5; tgt_rvalid = '0;
        #2 chk("rw_stall", 64'(stall), 64'(1));
        @(negedge clk); req_valid = 1'b0;
        #2 chk("rw_sel", 64'(tgt_sel), 64'(4'b0010));
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        chk("rw_sel_after", 64'(tgt_sel), 64'(0));
        chk("rw_stall_after", 64'(stall), 64'(0));
        @(negedge clk); reset = 1'b0; tgt_rvalid = 4'b0010;
        @(posedge clk); #1;
        exp_rd = '0; exp_data = '0; exp_err_addr = '0;
        chk("late_wb_valid", 64'(wb_valid), 64'(0));
        chk("late_err", 64'(err), 64'(0));
        chk("late_sel", 64'(tgt_sel), 64'(0));
        check_held();

        // Randomized ops, many back-to-back
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 4);
            if (r < 3)       a = 32'(r * 32'h200) + 32'($urandom_range(0, 32'h1FF));
            else if (r == 3) a = 32'h800 + 32'($urandom_range(0, 32'h7FF));
            else             a = $urandom | 32'h1000_0000;
            r = $urandom_range(0, 9);
            lat = (r < 8) ? (r % 4) : ((r == 8) ? TO - 1 : TO + 3);
            do_op(a, 1'($urandom), $urandom, 4'($urandom), RDW'($urandom), lat, $urandom, 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
